lpc_io_arbiter: RTL and testbench
=================================

# lpc_io_arbiter

Backend cycle sequencer between the LPC peripheral front end and the I/O devices behind it (POST code latch, COM UART, future slots). It decodes each front-end I/O read/write against a set of runtime-configurable address windows and sequences one device access at a time with chip-select, strobe and ready handshake. It returns read data and a completion pulse to the front end, with a bounded wait and a no-claim indication for unmatched addresses. It replaces the hand-written per-device `addr_hit`/`device_cs` comparators at top level.

## Interface
- `NUM_DEV`, 4: number of device windows/slots (1..8).
- `TIMEOUT`, 15: max cycles waited for `dev_ready` before abort (1..255).
- `lclk`  in  1  LPC clock (33 MHz); all logic on rising edge.
- `lreset`  in  1  reset; synchronous, active-high.
- `io_rden`  in  1  front-end I/O read request, single-cycle pulse.
- `io_wren`  in  1  front-end I/O write request, single-cycle pulse.
- `lpc_addr`  in  16  I/O address, valid with request pulse.
- `lpc_wdata`  in  8  write data, valid with `io_wren`.
- `lpc_rdata`  out  8  read data, valid with `cyc_done`.
- `cyc_done`  out  1  one-cycle completion pulse.
- `cyc_hit`  out  1  valid with `cyc_done`: 1 = a device claimed the cycle.
- `cyc_timeout`  out  1  one-cycle pulse with `cyc_done` when a wait aborted.
- `req_drop`  out  1  one-cycle pulse: request ignored (busy or rden&wren together).
- `win_en`  in  NUM_DEV  per-window enable.
- `win_base`  in  16*NUM_DEV  window base addresses, slot i at [16i+15:16i].
- `win_size`  in  3*NUM_DEV  window size as log2 bytes (0 = 1 byte .. 7 = 128 bytes).
- `dev_cs`  out  NUM_DEV  one-hot select, held for the whole device access.
- `dev_rd`  out  1  one-cycle read strobe, qualified by `dev_cs`.
- `dev_wr`  out  1  one-cycle write strobe, qualified by `dev_cs`.
- `dev_addr`  out  7  offset within the selected window.
- `dev_wdata`  out  8  registered write data.
- `dev_rdata`  in  8*NUM_DEV  per-slot read data.
- `dev_ready`  in  NUM_DEV  per-slot ready/ack.

## Operation
- States: IDLE, DECODE, STROBE, WAIT, DONE.
- IDLE: exactly one of `io_rden`/`io_wren` high -> latch addr, wdata, direction; go DECODE.
- IDLE, both high -> `req_drop` pulse, stay IDLE.
- Any request pulse while not IDLE -> `req_drop` pulse; request discarded, current cycle unaffected.
- DECODE: window i matches when `win_en[i]` is 1 and (addr & ~M) == (`win_base[i]` & ~M), where M = (1<<`win_size[i]`)-1.
- Overlapping matches: lowest index wins.
- Config is sampled only in DECODE; later changes do not affect the cycle in flight.
- No match: go DONE with `cyc_hit`=0 and `lpc_rdata`=8'hFF.
- Match: register `sel`, set `dev_addr` = addr & M (7 bits, upper bits zero), go STROBE.
- STROBE: `dev_cs[sel]`=1; `dev_rd` or `dev_wr` pulses this cycle only. `dev_ready[sel]` is sampled from this cycle on.
- WAIT: `dev_cs` held. Ready -> latch `dev_rdata[sel]` (reads), go DONE with `cyc_hit`=1.
- Wait counter is 8-bit, cleared at STROBE, incremented each non-ready cycle.
- Counter reaches TIMEOUT -> DONE with `cyc_hit`=1, `cyc_timeout`=1, `lpc_rdata`=8'hFF; the write is considered lost.
- DONE: `cyc_done` pulse; `dev_cs` cleared; return to IDLE.
- `dev_ready` of unselected slots is ignored.

## Timing
- Request at edge 0; DECODE at 1; STROBE at 2.
- Ready sampled high in STROBE -> DONE at 3, so `cyc_done` is at cycle 3 (minimum latency 3).
- No-match `cyc_done` at cycle 2.
- Timeout `cyc_done` at cycle 3+TIMEOUT.
- New request accepted in the cycle after DONE; back-to-back throughput is 4 cycles minimum.
- All outputs registered.
- Reset values: state IDLE; `dev_cs`=0, `dev_rd`=`dev_wr`=0, `dev_addr`=0, `dev_wdata`=0; `lpc_rdata`=8'hFF; `cyc_done`=`cyc_hit`=`cyc_timeout`=`req_drop`=0.
- Reset mid-cycle: all of the above apply on the next edge, strobes and `dev_cs` drop immediately, no `cyc_done` is issued, and the pending access is abandoned.

## Structure
- Package `lpc_io_pkg`: state enum, `LPC_IDLE_DATA`=8'hFF, default bases `LPC_POST_BASE`=16'h0080 and `LPC_COM0_BASE`=16'h03F8, `LPC_DEF_TIMEOUT`=15.
- Sub-module `lpc_io_window_match`: combinational, one instance per window; inputs addr/base/size/en, outputs hit and 7-bit offset. Priority encode and FSM stay in the parent.

## Test plan
- Win0 0x0080 size 0, win1 0x03F8 size 3. Write 0x55 to 0x0080, slot 0 ready in STROBE -> `dev_cs`=0001, `dev_wr` pulse at cycle 2, `dev_wdata`=0x55, `cyc_done`+`cyc_hit` at cycle 3.
- Read 0x03FD, slot 1 ready after 2 wait cycles with `dev_rdata`=0xA7 -> `dev_addr`=5, `lpc_rdata`=0xA7 with `cyc_done` at cycle 5.
- Read 0x0081 (no window) -> `cyc_done` at cycle 2, `cyc_hit`=0, `lpc_rdata`=0xFF, `dev_cs` stays 0.
- Read 0x03F8, slot 1 never ready, TIMEOUT=15 -> `cyc_done`+`cyc_timeout` at cycle 18, `lpc_rdata`=0xFF, `dev_cs` cleared.
- Win2 0x03F8 size 7 overlapping win1; second request during WAIT; rden&wren together -> win1 selected; `req_drop` pulses for the mid-WAIT request and for rden&wren; neither starts a cycle.
- `lreset` asserted in WAIT -> next edge: `dev_cs`=0, state IDLE, no `cyc_done`; a following write to 0x0080 completes normally.

Source files
------------

// File: rtl/lpc_io_pkg.sv
// rtl/lpc_io_pkg.sv - shared types and constants for the LPC I/O backend sequencer
// Contents: cycle state enum, idle read data, default device bases, default wait bound,
//           window mask helper.
package lpc_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } lpc_io_state_t;

  localparam logic [7:0]  LPC_IDLE_DATA   = 8'hFF;
  localparam logic [15:0] LPC_POST_BASE   = 16'h0080;
  localparam logic [15:0] LPC_COM0_BASE   = 16'h03F8;
  localparam int          LPC_DEF_TIMEOUT = 15;

  // Low-order address bits covered by a window of 2**size bytes.
  function automatic logic [15:0] win_mask(input logic [2:0] size);
    return (16'd1 << size) - 16'd1;
  endfunction

endpackage

// File: rtl/lpc_io_window_match.sv
// rtl/lpc_io_window_match.sv - combinational address match for one I/O window
// Ports: addr   - latched cycle address
//        base   - window base address
//        size   - window size as log2 bytes
//        en     - window enable
//        hit    - window claims addr
//        offset - addr offset inside the window (bits above the window are zero)
module lpc_io_window_match
  import lpc_io_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [15:0] base,
  input  logic [2:0]  size,
  input  logic        en,
  output logic        hit,
  output logic [6:0]  offset
);

  logic [15:0] mask;

  assign mask   = win_mask(size);
  assign hit    = en && ((addr & ~mask) == (base & ~mask));
  assign offset = addr[6:0] & mask[6:0];

endmodule

// File: rtl/lpc_io_arbiter.sv
// rtl/lpc_io_arbiter.sv - decodes LPC I/O cycles to device windows and sequences one access
// Ports: lclk/lreset                 - clock, synchronous active-high reset
//        io_rden/io_wren/lpc_addr/lpc_wdata - front-end request pulse, address, write data
//        lpc_rdata/cyc_done/cyc_hit/cyc_timeout/req_drop - completion info back to the front end
//        win_en/win_base/win_size    - per-slot window configuration (sampled in DECODE)
//        dev_cs/dev_rd/dev_wr/dev_addr/dev_wdata - device-side select, strobes, offset, data
//        dev_rdata/dev_ready         - per-slot read data and ready
module lpc_io_arbiter
  import lpc_io_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = LPC_DEF_TIMEOUT
) (
  input  logic                   lclk,
  input  logic                   lreset,
  input  logic                   io_rden,
  input  logic                   io_wren,
  input  logic [15:0]            lpc_addr,
  input  logic [7:0]             lpc_wdata,
  output logic [7:0]             lpc_rdata,
  output logic                   cyc_done,
  output logic                   cyc_hit,
  output logic                   cyc_timeout,
  output logic                   req_drop,
  input  logic [NUM_DEV-1:0]     win_en,
  input  logic [16*NUM_DEV-1:0]  win_base,
  input  logic [3*NUM_DEV-1:0]   win_size,
  output logic [NUM_DEV-1:0]     dev_cs,
  output logic                   dev_rd,
  output logic                   dev_wr,
  output logic [6:0]             dev_addr,
  output logic [7:0]             dev_wdata,
  input  logic [8*NUM_DEV-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]     dev_ready
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lpc_io_state_t      state;
  logic [15:0]        addr_q;
  logic               is_write;
  logic [7:0]         wait_cnt;

  logic [NUM_DEV-1:0] win_hit;
  logic [6:0]         win_off [NUM_DEV];
  logic [NUM_DEV-1:0] hit_oh;
  logic [6:0]         hit_off;
  logic               sel_ready;
  logic [7:0]         sel_rdata;

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_win
    lpc_io_window_match u_match (
      .addr   (addr_q),
      .base   (win_base[16*i +: 16]),
      .size   (win_size[3*i +: 3]),
      .en     (win_en[i]),
      .hit    (win_hit[i]),
      .offset (win_off[i])
    );
  end

  // Scan from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    hit_oh  = '0;
    hit_off = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_off   = win_off[i];
      end
    end
  end

  // dev_cs is one-hot and stays on through STROBE/WAIT, so it doubles as the slot select.
  assign sel_ready = |(dev_ready & dev_cs);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_cs[i]) sel_rdata = sel_rdata | dev_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge lclk) begin
    if (lreset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      is_write    <= 1'b0;
      wait_cnt    <= '0;
      dev_cs      <= '0;
      dev_rd      <= 1'b0;
      dev_wr      <= 1'b0;
      dev_addr    <= '0;
      dev_wdata   <= '0;
      lpc_rdata   <= LPC_IDLE_DATA;
      cyc_done    <= 1'b0;
      cyc_hit     <= 1'b0;
      cyc_timeout <= 1'b0;
      req_drop    <= 1'b0;
    end else begin
      cyc_done    <= 1'b0;
      cyc_hit     <= 1'b0;
      cyc_timeout <= 1'b0;
      dev_rd      <= 1'b0;
      dev_wr      <= 1'b0;
      req_drop    <= (io_rden || io_wren) &&
                     ((state != ST_IDLE) || (io_rden && io_wren));

      case (state)
        ST_IDLE: begin
          if (io_rden ^ io_wren) begin
            addr_q   <= lpc_addr;
            is_write <= io_wren;
            if (io_wren) dev_wdata <= lpc_wdata;
            state    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (|hit_oh) begin
            dev_cs   <= hit_oh;
            dev_addr <= hit_off;
            dev_rd   <= !is_write;
            dev_wr   <= is_write;
            wait_cnt <= '0;
            state    <= ST_STROBE;
          end else begin
            cyc_done  <= 1'b1;
            lpc_rdata <= LPC_IDLE_DATA;
            state     <= ST_DONE;
          end
        end

        ST_STROBE, ST_WAIT: begin
          if (sel_ready) begin
            dev_cs    <= '0;
            cyc_done  <= 1'b1;
            cyc_hit   <= 1'b1;
            lpc_rdata <= is_write ? LPC_IDLE_DATA : sel_rdata;
            state     <= ST_DONE;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            dev_cs      <= '0;
            cyc_done    <= 1'b1;
            cyc_hit     <= 1'b1;
            cyc_timeout <= 1'b1;
            lpc_rdata   <= LPC_IDLE_DATA;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            state    <= ST_WAIT;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_io_arbiter.sv
// tb/tb_lpc_io_arbiter.sv - self-checking bench for lpc_io_arbiter
module tb_lpc_io_arbiter;
  import lpc_io_pkg::*;

  localparam int NUM_DEV = 4;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 999;

  logic                  lclk = 1'b0;
  logic                  lreset;
  logic                  io_rden, io_wren;
  logic [15:0]           lpc_addr;
  logic [7:0]            lpc_wdata;
  logic [7:0]            lpc_rdata;
  logic                  cyc_done, cyc_hit, cyc_timeout, req_drop;
  logic [NUM_DEV-1:0]    win_en;
  logic [16*NUM_DEV-1:0] win_base;
  logic [3*NUM_DEV-1:0]  win_size;
  logic [NUM_DEV-1:0]    dev_cs;
  logic                  dev_rd, dev_wr;
  logic [6:0]            dev_addr;
  logic [7:0]            dev_wdata;
  logic [8*NUM_DEV-1:0]  dev_rdata;
  logic [NUM_DEV-1:0]    dev_ready;

  always #5 lclk = ~lclk;

  lpc_io_arbiter #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
    .lclk(lclk), .lreset(lreset), .io_rden(io_rden), .io_wren(io_wren),
    .lpc_addr(lpc_addr), .lpc_wdata(lpc_wdata), .lpc_rdata(lpc_rdata),
    .cyc_done(cyc_done), .cyc_hit(cyc_hit), .cyc_timeout(cyc_timeout),
    .req_drop(req_drop), .win_en(win_en), .win_base(win_base), .win_size(win_size),
    .dev_cs(dev_cs), .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] cfg_base [NUM_DEV];
  logic [2:0]  cfg_size [NUM_DEV];
  logic        cfg_en   [NUM_DEV];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          dly;
    logic [7:0]  rdv;
    int          inj;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NUM_DEV; i++) begin
      win_base[16*i +: 16] = cfg_base[i];
      win_size[3*i +: 3]   = cfg_size[i];
      win_en[i]            = cfg_en[i];
    end
  endtask

  // One front-end cycle. dly = cycles after STROBE before the selected slot is ready
  // (NEVER = not ready). inj > 0 injects a stray read request in that cycle; inj < 0 picks
  // one at random. rnd adds ready noise on other slots and scrambles config after DECODE.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                         input int dly, input logic [7:0] rdv, input int inj_in, input bit rnd);
    int exp_sel, exp_done, cyc, done_cyc, n_strobe, n_drop, cs_err, st_cyc, inj;
    bit exp_to;
    logic [6:0] exp_off;
    logic [NUM_DEV-1:0] sel_mask, exp_cs;
    logic got_hit, got_to, st_rd, st_wr;
    logic [7:0] got_rd, st_wdata;
    logic [6:0] st_addr;

    // Reference: lowest enabled window whose address bits above the window size agree.
    exp_sel = -1;
    exp_off = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (exp_sel < 0 && cfg_en[i] &&
          ((addr >> cfg_size[i]) == (cfg_base[i] >> cfg_size[i]))) begin
        exp_sel = i;
        exp_off = 7'(int'(addr) % (1 << cfg_size[i]));
      end
    end
    exp_to = 1'b0;
    if (exp_sel < 0) exp_done = 2;
    else if (dly <= TIMEOUT) exp_done = 3 + dly;
    else begin
      exp_done = 3 + TIMEOUT;
      exp_to   = 1'b1;
    end
    inj = (inj_in < 0) ? (($urandom_range(0, 1) == 1) ? $urandom_range(1, exp_done - 1) : 0)
                       : inj_in;
    sel_mask = '0;
    if (exp_sel >= 0) sel_mask[exp_sel] = 1'b1;

    for (int i = 0; i < NUM_DEV; i++)
      dev_rdata[8*i +: 8] = (i == exp_sel) ? rdv : 8'($urandom);
    io_rden   = !wr;
    io_wren   = wr;
    lpc_addr  = addr;
    lpc_wdata = wd;
    dev_ready = rnd ? (NUM_DEV'($urandom) & ~sel_mask) : '0;

    cyc = 0; done_cyc = -1; n_strobe = 0; n_drop = 0; cs_err = 0; st_cyc = -1;
    got_hit = 0; got_to = 0; got_rd = '0; st_rd = 0; st_wr = 0; st_addr = '0; st_wdata = '0;
    while (cyc < 300 && done_cyc < 0) begin
      tick();
      cyc++;
      io_rden   = (inj == cyc);
      io_wren   = 1'b0;
      lpc_addr  = 16'($urandom);
      lpc_wdata = 8'($urandom);
      if (rnd && cyc == 2) begin
        for (int i = 0; i < NUM_DEV; i++) begin
          win_base[16*i +: 16] = 16'($urandom);
          win_en[i]            = 1'($urandom);
        end
      end
      dev_ready = (rnd ? (NUM_DEV'($urandom) & ~sel_mask) : '0) |
                  ((cyc >= 2 + dly) ? sel_mask : '0);
      if (req_drop) n_drop++;
      exp_cs = (cyc >= 2 && cyc < exp_done) ? sel_mask : '0;
      if (dev_cs !== exp_cs) cs_err++;
      if (dev_rd || dev_wr) begin
        n_strobe++;
        st_cyc = cyc; st_rd = dev_rd; st_wr = dev_wr; st_addr = dev_addr; st_wdata = dev_wdata;
      end
      if (cyc_done) begin
        done_cyc = cyc; got_hit = cyc_hit; got_to = cyc_timeout; got_rd = lpc_rdata;
      end
    end
    dev_ready = '0;

    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("cyc_hit", 32'(got_hit), 32'(exp_sel >= 0));
    chk("cyc_timeout", 32'(got_to), 32'(exp_to));
    if (!wr) chk("lpc_rdata", 32'(got_rd), 32'((exp_sel >= 0 && !exp_to) ? rdv : 8'hFF));
    chk("strobe_count", 32'(n_strobe), 32'(exp_sel >= 0));
    chk("dev_cs_track", 32'(cs_err), 32'd0);
    chk("req_drop_count", 32'(n_drop), 32'(inj > 0));
    if (exp_sel >= 0) begin
      chk("strobe_cycle", 32'(st_cyc), 32'd2);
      chk("strobe_dir", 32'({st_wr, st_rd}), 32'({wr, !wr}));
      chk("dev_addr", 32'(st_addr), 32'(exp_off));
      if (wr) chk("dev_wdata", 32'(st_wdata), 32'(wd));
    end
    tick();
  endtask

  initial begin
    int n_done, n_cs, n_strb;
    lreset = 1'b1; io_rden = 0; io_wren = 0; lpc_addr = '0; lpc_wdata = '0;
    dev_ready = '0; dev_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      cfg_base[i] = '0; cfg_size[i] = '0; cfg_en[i] = 1'b0;
    end
    apply_cfg();
    tick(); tick();
    chk("rst_dev_cs", 32'(dev_cs), 32'd0);
    chk("rst_strobes", 32'({dev_rd, dev_wr}), 32'd0);
    chk("rst_dev_addr", 32'(dev_addr), 32'd0);
    chk("rst_dev_wdata", 32'(dev_wdata), 32'd0);
    chk("rst_lpc_rdata", 32'(lpc_rdata), 32'hFF);
    chk("rst_flags", 32'({cyc_done, cyc_hit, cyc_timeout, req_drop}), 32'd0);
    lreset = 1'b0;
    tick();

    cfg_base[0] = LPC_POST_BASE; cfg_size[0] = 3'd0; cfg_en[0] = 1'b1;
    cfg_base[1] = LPC_COM0_BASE; cfg_size[1] = 3'd3; cfg_en[1] = 1'b1;
    apply_cfg();

    vecs[0] = '{wr: 1'b1, addr: 16'h0080, wd: 8'h55, dly: 0,     rdv: 8'h00, inj: 0};
    vecs[1] = '{wr: 1'b0, addr: 16'h03FD, wd: 8'h00, dly: 2,     rdv: 8'hA7, inj: 0};
    vecs[2] = '{wr: 1'b0, addr: 16'h0081, wd: 8'h00, dly: 0,     rdv: 8'h12, inj: 0};
    vecs[3] = '{wr: 1'b0, addr: 16'h03F8, wd: 8'h00, dly: NEVER, rdv: 8'h34, inj: 0};
    vecs[4] = '{wr: 1'b1, addr: 16'h03FF, wd: 8'h3C, dly: 14,    rdv: 8'h00, inj: 0};
    vecs[5] = '{wr: 1'b0, addr: 16'h0080, wd: 8'h00, dly: 16,    rdv: 8'h11, inj: 0};
    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].dly, vecs[v].rdv, vecs[v].inj, 1'b0);

    // Overlapping window 2 covers 0x0380-0x03FF; window 1 must still win at 0x03F8.
    cfg_base[2] = LPC_COM0_BASE; cfg_size[2] = 3'd7; cfg_en[2] = 1'b1;
    apply_cfg();
    run_txn(1'b0, 16'h03F8, 8'h00, 4, 8'h6B, 3, 1'b0);
    run_txn(1'b0, 16'h03A0, 8'h00, 1, 8'h9D, 0, 1'b0);

    // Read and write requested together in IDLE: dropped, nothing starts.
    io_rden = 1'b1; io_wren = 1'b1; lpc_addr = 16'h0080;
    tick();
    io_rden = 1'b0; io_wren = 1'b0;
    chk("both_req_drop", 32'(req_drop), 32'd1);
    n_done = 0; n_cs = 0; n_strb = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cyc_done) n_done++;
      if (dev_cs != '0) n_cs++;
      if (dev_rd || dev_wr) n_strb++;
    end
    chk("both_no_cycle", 32'(n_done + n_cs + n_strb), 32'd0);

    // Reset while waiting on a device that never answers.
    io_rden = 1'b1; lpc_addr = 16'h03F8;
    tick();
    io_rden = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_cs", 32'(dev_cs), 32'b0010);
    lreset = 1'b1;
    tick();
    lreset = 1'b0;
    chk("reset_cs_cleared", 32'(dev_cs), 32'd0);
    chk("reset_no_done", 32'({cyc_done, dev_rd, dev_wr}), 32'd0);
    n_done = 0; n_cs = 0;
    for (int c = 0; c < TIMEOUT + 5; c++) begin
      tick();
      if (cyc_done) n_done++;
      if (dev_cs != '0) n_cs++;
    end
    chk("reset_abandoned", 32'(n_done + n_cs), 32'd0);
    run_txn(1'b1, 16'h0080, 8'hC3, 0, 8'h00, 0, 1'b0);

    // Randomized cycles against the reference computation.
    for (int t = 0; t < 80; t++) begin
      logic [15:0] a;
      int k, d;
      for (int i = 0; i < NUM_DEV; i++) begin
        cfg_en[i]   = ($urandom_range(0, 3) != 0);
        cfg_base[i] = 16'($urandom);
        cfg_size[i] = 3'($urandom);
      end
      apply_cfg();
      k = $urandom_range(0, NUM_DEV - 1);
      a = ($urandom_range(0, 3) != 0) ? (cfg_base[k] ^ 16'($urandom_range(0, 255)))
                                      : 16'($urandom);
      d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, 14);
      run_txn(1'($urandom), a, 8'($urandom), d, 8'($urandom), -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
